sm_ram_arbiter: RTL and testbench

- Shares the single data-RAM port between two requesters: port 0 is the CPU load/store path and port 1 is the debug/loader master.
- Arbitration is round-robin, decided in the same cycle as the request.
- A requester can lock the port for a bounded burst.
- Read data returns one cycle after grant, matching the synchronous-read RAM.
- Sits between the requesters and the RAM's A-port; the RAM side is a plain single-port interface.

---
 rtl/sm_ram_arbiter_pkg.sv | 13 +
 rtl/sm_rr_pick2.sv | 17 +
 rtl/sm_ram_arbiter.sv | 149 ++++++++++++++
 tb/tb_sm_ram_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_ram_arbiter_pkg.sv
// Shared types for the data-RAM port arbiter.
// State encoding and counter width used by the arbiter FSM.
package sm_ram_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_LOCK0 = 2'd1,
      ARB_LOCK1 = 2'd2
   } arbState_t;

   localparam int CNT_W = 8;

endpackage

// File: rtl/sm_rr_pick2.sv
// Two-input priority picker.
// Grants the lone requester, or the prio port when both ask.
module sm_rr_pick2 (
   input  logic       req0,
   input  logic       req1,
   input  logic       prio,
   output logic [1:0] gnt
);

   // Pick one winner: a lone request wins, a tie goes to prio.
   always_comb begin
      gnt    = 2'b00;
      gnt[0] = req0 & (~req1 | ~prio);
      gnt[1] = req1 & (~req0 | prio);
   end

endmodule

// File: rtl/sm_ram_arbiter.sv
// Round-robin arbiter sharing the data-RAM A-port.
// Port 0 is the CPU path, port 1 the debug/loader master.
module sm_ram_arbiter
   import sm_ram_arbiter_pkg::*;
#(
   parameter int AW        = 5,
   parameter int DW        = 32,
   parameter int MAX_BURST = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic          lock0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          gnt0,
   output logic          rvalid0,
   output logic [DW-1:0] rdata0,
   input  logic          req1,
   input  logic          lock1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt1,
   output logic          rvalid1,
   output logic [DW-1:0] rdata1,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata,
   output logic          owner
);

   localparam logic [CNT_W-1:0] MaxBurst = CNT_W'(MAX_BURST);
   localparam logic             LockEn   = (MAX_BURST > 1);

   arbState_t        state, stateNext;
   logic             prio, prioNext;
   logic [CNT_W-1:0] burstCnt, cntNext;
   logic [1:0]       pick, gntRaw;

   sm_rr_pick2 uPick (
      .req0 (req0),
      .req1 (req1),
      .prio (prio),
      .gnt  (pick)
   );

   // Grant decode, lock entry/exit and burst counting.
   always_comb begin
      gntRaw    = 2'b00;
      stateNext = state;
      prioNext  = prio;
      cntNext   = burstCnt;
      unique case (state)
         ARB_IDLE: begin
            gntRaw  = pick;
            cntNext = '0;
            if (pick[0]) begin
               if (lock0 && LockEn) begin
                  stateNext = ARB_LOCK0;
                  cntNext   = CNT_W'(1);
               end else begin
                  prioNext = 1'b1;
               end
            end else if (pick[1]) begin
               if (lock1 && LockEn) begin
                  stateNext = ARB_LOCK1;
                  cntNext   = CNT_W'(1);
               end else begin
                  prioNext = 1'b0;
               end
            end
         end
         ARB_LOCK0: begin
            gntRaw[0] = req0;
            if (req0) begin
               cntNext = burstCnt + CNT_W'(1);
               if (!lock0 || cntNext == MaxBurst) begin
                  stateNext = ARB_IDLE;
                  prioNext  = 1'b1;
                  cntNext   = '0;
               end
            end else if (!lock0) begin
               stateNext = ARB_IDLE;
               prioNext  = 1'b1;
               cntNext   = '0;
            end
         end
         ARB_LOCK1: begin
            gntRaw[1] = req1;
            if (req1) begin
               cntNext = burstCnt + CNT_W'(1);
               if (!lock1 || cntNext == MaxBurst) begin
                  stateNext = ARB_IDLE;
                  prioNext  = 1'b0;
                  cntNext   = '0;
               end
            end else if (!lock1) begin
               stateNext = ARB_IDLE;
               prioNext  = 1'b0;
               cntNext   = '0;
            end
         end
         default: begin
            stateNext = ARB_IDLE;
            cntNext   = '0;
         end
      endcase
   end

   // Grants are masked during reset; RAM follows the selected port.
   always_comb begin
      gnt0      = gntRaw[0] & rst_n;
      gnt1      = gntRaw[1] & rst_n;
      owner     = gnt1 ? 1'b1 : (gnt0 ? 1'b0 : prio);
      ram_addr  = owner ? addr1 : addr0;
      ram_wdata = owner ? wdata1 : wdata0;
      ram_we    = (gnt0 & we0) | (gnt1 & we1);
      rdata0    = ram_rdata;
      rdata1    = ram_rdata;
   end

   // Arbitration state, priority and burst length.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ARB_IDLE;
         prio     <= 1'b0;
         burstCnt <= '0;
      end else begin
         state    <= stateNext;
         prio     <= prioNext;
         burstCnt <= cntNext;
      end
   end

   // Read-valid tracks the synchronous RAM read latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
      end else begin
         rvalid0 <= gnt0 & ~we0;
         rvalid1 <= gnt1 & ~we1;
      end
   end

endmodule

// File: tb/tb_sm_ram_arbiter.sv
// Self-checking bench for sm_ram_arbiter.
// Directed scenarios plus randomized traffic against a rule model.
module tb_sm_ram_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int MB = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    req, lock, we;
   logic [AW-1:0] addr [2];
   logic [DW-1:0] wdata [2];
   logic          gnt0, gnt1, rvalid0, rvalid1, ram_we, owner;
   logic [DW-1:0] rdata0, rdata1, ram_wdata, ram_rdata;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] tbRam [32];

   int            checks = 0;
   int            errors = 0;

   int            mLock;
   int            mBeats;
   bit            mPrio;
   logic [DW-1:0] mem [32];
   bit   [1:0]    mRv;
   logic [DW-1:0] mRd [2];

   sm_ram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req[0]),
      .lock0     (lock[0]),
      .we0       (we[0]),
      .addr0     (addr[0]),
      .wdata0    (wdata[0]),
      .gnt0      (gnt0),
      .rvalid0   (rvalid0),
      .rdata0    (rdata0),
      .req1      (req[1]),
      .lock1     (lock[1]),
      .we1       (we[1]),
      .addr1     (addr[1]),
      .wdata1    (wdata[1]),
      .gnt1      (gnt1),
      .rvalid1   (rvalid1),
      .rdata1    (rdata1),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .owner     (owner)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM: read returns pre-write contents.
   always @(posedge clk) begin
      if (ram_we) tbRam[ram_addr] <= ram_wdata;
      ram_rdata <= tbRam[ram_addr];
   end

   function automatic logic [1:0] expGnt();
      if (!rst_n) return 2'b00;
      if (mLock >= 0) begin
         if (!req[mLock]) return 2'b00;
         return (mLock == 1) ? 2'b10 : 2'b01;
      end
      if (req == 2'b11) return mPrio ? 2'b10 : 2'b01;
      return req;
   endfunction

   task automatic modelReset();
      mLock  = -1;
      mBeats = 0;
      mPrio  = 1'b0;
      mRv    = 2'b00;
   endtask

   // Advance the model by one clock, then move past the edge.
   task automatic modelStep();
      logic [1:0] g;
      g = expGnt();
      for (int k = 0; k < 2; k++) begin
         mRv[k] = g[k] & ~we[k];
         mRd[k] = mem[addr[k]];
      end
      for (int k = 0; k < 2; k++)
         if (g[k] && we[k]) mem[addr[k]] = wdata[k];
      if (mLock < 0) begin
         for (int k = 0; k < 2; k++)
            if (g[k]) begin
               if (lock[k] && MB > 1) begin
                  mLock  = k;
                  mBeats = 1;
               end else begin
                  mPrio = (k == 0);
               end
            end
      end else begin
         if (g[mLock]) begin
            mBeats++;
            if (!lock[mLock] || mBeats == MB) begin
               mPrio = (mLock == 0);
               mLock = -1;
            end
         end else if (!lock[mLock]) begin
            mPrio = (mLock == 0);
            mLock = -1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic applyReset();
      rst_n = 1'b0;
      req   = 2'b00;
      lock  = 2'b00;
      we    = 2'b00;
      modelReset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      req  = 2'b11;
      we   = 2'b11;
      lock = 2'b00;
      #2;
      checks++;
      if ({gnt1, gnt0} !== 2'b00) begin
         errors++;
         $display("FAIL reset_gnt got=%b want=00", {gnt1, gnt0});
      end
      checks++;
      if (ram_we !== 1'b0) begin
         errors++;
         $display("FAIL reset_we got=%b want=0", ram_we);
      end
      checks++;
      if ({rvalid1, rvalid0} !== 2'b00 || owner !== 1'b0) begin
         errors++;
         $display("FAIL reset_rv_owner rv=%b owner=%b want 00/0",
                  {rvalid1, rvalid0}, owner);
      end
      req = 2'b00;
      we  = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_read();
      req     = 2'b01;
      we      = 2'b00;
      lock    = 2'b00;
      addr[0] = AW'(3);
      @(negedge clk);
      checks++;
      if ({gnt1, gnt0} !== 2'b01 || ram_addr !== AW'(3)) begin
         errors++;
         $display("FAIL single_gnt gnt=%b addr=%0d want 01/3",
                  {gnt1, gnt0}, ram_addr);
      end
      modelStep();
      req = 2'b00;
      @(negedge clk);
      checks++;
      if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL single_rdata rv=%b data=%h want 1/deadbeef",
                  rvalid0, rdata0);
      end
      checks++;
      if (rvalid1 !== 1'b0 || gnt1 !== 1'b0) begin
         errors++;
         $display("FAIL single_port1 rv1=%b gnt1=%b want 0/0",
                  rvalid1, gnt1);
      end
      modelStep();
   endtask

   task automatic test_alternate();
      logic [1:0] want [4];
      want = '{2'b01, 2'b10, 2'b01, 2'b10};
      applyReset();
      req     = 2'b11;
      lock    = 2'b00;
      we      = 2'b00;
      addr[0] = AW'(1);
      addr[1] = AW'(2);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if ({gnt1, gnt0} !== want[i] ||
             ram_addr !== (want[i][1] ? AW'(2) : AW'(1))) begin
            errors++;
            $display("FAIL alt_%0d gnt=%b addr=%0d want gnt=%b",
                     i, {gnt1, gnt0}, ram_addr, want[i]);
         end
         modelStep();
      end
      req = 2'b00;
      modelStep();
   endtask

   task automatic test_write_read();
      req      = 2'b10;
      we       = 2'b10;
      addr[1]  = AW'(7);
      wdata[1] = 32'h12345678;
      @(negedge clk);
      checks++;
      if (gnt1 !== 1'b1 || ram_we !== 1'b1) begin
         errors++;
         $display("FAIL wr_cycle gnt1=%b we=%b want 1/1", gnt1, ram_we);
      end
      modelStep();
      req     = 2'b01;
      we      = 2'b00;
      addr[0] = AW'(7);
      @(negedge clk);
      checks++;
      if (gnt0 !== 1'b1 || ram_we !== 1'b0 || rvalid1 !== 1'b0) begin
         errors++;
         $display("FAIL rd_cycle gnt0=%b we=%b rv1=%b want 1/0/0",
                  gnt0, ram_we, rvalid1);
      end
      modelStep();
      req = 2'b00;
      @(negedge clk);
      checks++;
      if (rvalid0 !== 1'b1 || rdata0 !== 32'h12345678) begin
         errors++;
         $display("FAIL wr_rd_data rv=%b data=%h want 1/12345678",
                  rvalid0, rdata0);
      end
      modelStep();
   endtask

   task automatic test_burst_max();
      logic [1:0] w;
      req  = 2'b11;
      lock = 2'b10;
      we   = 2'b00;
      for (int i = 0; i < 10; i++) begin
         w = (i == 8) ? 2'b01 : 2'b10;
         @(negedge clk);
         checks++;
         if ({gnt1, gnt0} !== w) begin
            errors++;
            $display("FAIL burst_max_%0d gnt=%b want=%b",
                     i, {gnt1, gnt0}, w);
         end
         modelStep();
      end
      req = 2'b00;
      lock = 2'b00;
      modelStep();
   endtask

   task automatic test_burst_release();
      logic [1:0] w;
      req = 2'b11;
      we  = 2'b00;
      for (int i = 0; i < 4; i++) begin
         lock = (i < 2) ? 2'b01 : 2'b00;
         w    = (i < 3) ? 2'b01 : 2'b10;
         @(negedge clk);
         checks++;
         if ({gnt1, gnt0} !== w) begin
            errors++;
            $display("FAIL burst_rel_%0d gnt=%b want=%b",
                     i, {gnt1, gnt0}, w);
         end
         modelStep();
      end
      req  = 2'b00;
      lock = 2'b00;
      modelStep();
   endtask

   task automatic test_reset_midburst();
      req     = 2'b10;
      lock    = 2'b10;
      we      = 2'b00;
      addr[1] = AW'(5);
      for (int i = 0; i < 4; i++) modelStep();
      checks++;
      if (rvalid1 !== 1'b1 || mRv[1] !== 1'b1) begin
         errors++;
         $display("FAIL midburst_pending rv1=%b want 1", rvalid1);
      end
      rst_n = 1'b0;
      req   = 2'b11;
      #1;
      checks++;
      if ({gnt1, gnt0} !== 2'b00 || {rvalid1, rvalid0} !== 2'b00) begin
         errors++;
         $display("FAIL midburst_rst gnt=%b rv=%b want 00/00",
                  {gnt1, gnt0}, {rvalid1, rvalid0});
      end
      @(negedge clk);
      rst_n = 1'b1;
      lock  = 2'b00;
      modelReset();
      #1;
      checks++;
      if ({gnt1, gnt0} !== 2'b01) begin
         errors++;
         $display("FAIL midburst_after gnt=%b want=01", {gnt1, gnt0});
      end
      modelStep();
      req = 2'b00;
      modelStep();
   endtask

   task automatic test_random();
      logic [1:0] eg;
      logic       eo;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         eg = expGnt();
         eo = eg[1] ? 1'b1 : (eg[0] ? 1'b0 : mPrio);
         checks++;
         if ({gnt1, gnt0} !== eg || owner !== eo) begin
            errors++;
            $display("FAIL rnd_gnt c=%0d gnt=%b own=%b want %b/%b",
                     c, {gnt1, gnt0}, owner, eg, eo);
         end
         checks++;
         if (ram_we !== |(eg & we) ||
             (eg != 2'b00 && ram_addr !== addr[eo])) begin
            errors++;
            $display("FAIL rnd_ram c=%0d we=%b addr=%0d", c, ram_we,
                     ram_addr);
         end
         checks++;
         if ({rvalid1, rvalid0} !== mRv ||
             (mRv[0] && rdata0 !== mRd[0]) ||
             (mRv[1] && rdata1 !== mRd[1])) begin
            errors++;
            $display("FAIL rnd_rd c=%0d rv=%b want=%b d0=%h d1=%h",
                     c, {rvalid1, rvalid0}, mRv, rdata0, rdata1);
         end
         modelStep();
         for (int k = 0; k < 2; k++) begin
            lock[k] = ($urandom_range(0, 2) != 0);
            if (eg[k] || !req[k]) begin
               req[k]   = ($urandom_range(0, 3) != 0);
               we[k]    = $urandom_range(0, 1) == 1;
               addr[k]  = AW'($urandom_range(0, 31));
               wdata[k] = $urandom;
            end
         end
      end
      req  = 2'b00;
      lock = 2'b00;
      repeat (3) modelStep();
   endtask

   initial begin
      rst_n    = 1'b0;
      req      = 2'b00;
      lock     = 2'b00;
      we       = 2'b00;
      addr[0]  = '0;
      addr[1]  = '0;
      wdata[0] = '0;
      wdata[1] = '0;
      modelReset();
      for (int i = 0; i < 32; i++) begin
         mem[i]   = $urandom;
         tbRam[i] <= mem[i];
      end
      mem[3]   = 32'hDEADBEEF;
      tbRam[3] <= 32'hDEADBEEF;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_single_read();
      test_alternate();
      test_write_read();
      test_burst_max();
      test_burst_release();
      test_reset_midburst();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
